// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// Latency: none (wires only).
// Backpressure: carries in_ready toward the producer and out_ready toward the block.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor reusing one CHUNK-bit NOR-built ripple stage, LSB chunk first.
// Latency: result valid NCHUNK cycles after acceptance; a new operand is accepted every NCHUNK+2 cycles at best.
// Backpressure: the result is held in DONE until out_ready; in_ready stays low until then.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_chunk_adder_if.slave bus
);
    localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("seq_chunk_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             overflow_r;

    // Working operands shift right one chunk per cycle so the stage always reads bits [CHUNK-1:0].
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;

    logic [CHUNK:0]   cy;
    logic [CHUNK-1:0] chunk_sum;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] sum_nxt;

    assign cy[0] = c_r;

    // Nine-NOR full adder per bit: n4 = a xnor b, n8 = a^b^c, n9 = carry.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic n1, n2, n3, n4, n5, n6, n7, n8, n9;
        nor u_n1 (n1, a_r[i], b_r[i]);
        nor u_n2 (n2, a_r[i], n1);
        nor u_n3 (n3, b_r[i], n1);
        nor u_n4 (n4, n2, n3);
        nor u_n5 (n5, n4, cy[i]);
        nor u_n6 (n6, n4, n5);
        nor u_n7 (n7, cy[i], n5);
        nor u_n8 (n8, n6, n7);
        nor u_n9 (n9, n1, n5);
        assign chunk_sum[i] = n8;
        assign cy[i+1]      = n9;
    end

    // Results enter at the top of sum_r so after NCHUNK shifts chunk 0 sits at the LSBs.
    if (NCHUNK == 1) begin : g_single
        assign a_nxt   = a_r;
        assign b_nxt   = b_r;
        assign sum_nxt = chunk_sum;
    end else begin : g_multi
        assign a_nxt   = {{CHUNK{1'b0}}, a_r[WIDTH-1:CHUNK]};
        assign b_nxt   = {{CHUNK{1'b0}}, b_r[WIDTH-1:CHUNK]};
        assign sum_nxt = {chunk_sum, sum_r[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b ^ {WIDTH{bus.sub}};
                        c_r        <= bus.carry_in ^ bus.sub;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    a_r     <= a_nxt;
                    b_r     <= b_nxt;
                    c_r     <= cy[CHUNK];
                    sum_r   <= sum_nxt;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        carry_out_r <= cy[CHUNK];
                        overflow_r  <= cy[CHUNK-1] ^ cy[CHUNK];
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at CHUNK = 4, 16 and 1 sharing one clock and reset.
// Expected results are hand-computed constants in the vector table.
module tb_seq_chunk_adder;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        iv   [3];
    logic        ordy [3];
    logic        ic   [3];
    logic        isb  [3];
    logic [15:0] ia   [3];
    logic [15:0] ib   [3];
    logic        ird  [3];
    logic        ovd  [3];
    logic        cod  [3];
    logic        ofd  [3];
    logic [15:0] sumd [3];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sb;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vt [8];
    int   lats [3];

    seq_chunk_adder_if #(.WIDTH(16)) bus4  ();
    seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
    seq_chunk_adder_if #(.WIDTH(16)) bus1  ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_c4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus4.in_valid  = iv[0];
    assign bus4.a         = ia[0];
    assign bus4.b         = ib[0];
    assign bus4.carry_in  = ic[0];
    assign bus4.sub       = isb[0];
    assign bus4.out_ready = ordy[0];
    assign bus16.in_valid  = iv[1];
    assign bus16.a         = ia[1];
    assign bus16.b         = ib[1];
    assign bus16.carry_in  = ic[1];
    assign bus16.sub       = isb[1];
    assign bus16.out_ready = ordy[1];
    assign bus1.in_valid  = iv[2];
    assign bus1.a         = ia[2];
    assign bus1.b         = ib[2];
    assign bus1.carry_in  = ic[2];
    assign bus1.sub       = isb[2];
    assign bus1.out_ready = ordy[2];

    assign ird[0] = bus4.in_ready;
    assign ovd[0] = bus4.out_valid;
    assign sumd[0] = bus4.sum;
    assign cod[0] = bus4.carry_out;
    assign ofd[0] = bus4.overflow;
    assign ird[1] = bus16.in_ready;
    assign ovd[1] = bus16.out_valid;
    assign sumd[1] = bus16.sum;
    assign cod[1] = bus16.carry_out;
    assign ofd[1] = bus16.overflow;
    assign ird[2] = bus1.in_ready;
    assign ovd[2] = bus1.out_valid;
    assign sumd[2] = bus1.sum;
    assign cod[2] = bus1.carry_out;
    assign ofd[2] = bus1.overflow;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One operation on DUT d; hold > 0 keeps out_ready low for that many DONE cycles
    // while offering a competing operand that must be ignored.
    task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo, input int lat, input int hold,
                         input string tag);
        int n;
        iv[d]   = 1'b1;
        ia[d]   = a;
        ib[d]   = b;
        ic[d]   = cin;
        isb[d]  = sb;
        ordy[d] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        iv[d]  = 1'b0;
        ia[d]  = ~a;
        ib[d]  = 16'h5a5a;
        ic[d]  = ~cin;
        isb[d] = ~sb;
        check({tag, "_busy_rdy"}, 32'(ird[d]), 32'd0);
        n = 0;
        while (!ovd[d] && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_vld"}, 32'(ovd[d]), 32'd1);
            check({tag, "_hold_sum"}, 32'(sumd[d]), 32'(es));
            check({tag, "_hold_rdy"}, 32'(ird[d]), 32'd0);
            iv[d] = 1'b1;
            ia[d] = 16'hffff;
            ib[d] = 16'hffff;
            @(posedge clk);
            @(negedge clk);
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        check({tag, "_sum"}, 32'(sumd[d]), 32'(es));
        check({tag, "_cout"}, 32'(cod[d]), 32'(ec));
        check({tag, "_ovf"}, 32'(ofd[d]), 32'(eo));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vld_after"}, 32'(ovd[d]), 32'd0);
        check({tag, "_rdy_after"}, 32'(ird[d]), 32'd1);
    endtask

    initial begin
        vt[0] = '{16'd1,     16'd1,     1'b1, 1'b0, 16'd3,     1'b0, 1'b0};
        vt[1] = '{16'd65535, 16'd1,     1'b0, 1'b0, 16'd0,     1'b1, 1'b0};
        vt[2] = '{16'd49151, 16'd65535, 1'b0, 1'b0, 16'd49150, 1'b1, 1'b0};
        vt[3] = '{16'd65535, 16'd65535, 1'b0, 1'b0, 16'd65534, 1'b1, 1'b0};
        vt[4] = '{16'd5,     16'd7,     1'b0, 1'b1, 16'd65534, 1'b0, 1'b0};
        vt[5] = '{16'd32767, 16'd1,     1'b0, 1'b0, 16'd32768, 1'b0, 1'b1};
        vt[6] = '{16'd32768, 16'd1,     1'b0, 1'b1, 16'd32767, 1'b1, 1'b1};
        vt[7] = '{16'd10,    16'd3,     1'b1, 1'b1, 16'd6,     1'b1, 1'b0};
        lats[0] = 4;
        lats[1] = 1;
        lats[2] = 16;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ia[i]   = '0;
            ib[i]   = '0;
            ic[i]   = 1'b0;
            isb[i]  = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_rdy_d%0d", d), 32'(ird[d]), 32'd1);
            check($sformatf("reset_vld_d%0d", d), 32'(ovd[d]), 32'd0);
            check($sformatf("reset_sum_d%0d", d), 32'(sumd[d]), 32'd0);
            check($sformatf("reset_cout_d%0d", d), 32'(cod[d]), 32'd0);
            check($sformatf("reset_ovf_d%0d", d), 32'(ofd[d]), 32'd0);
        end

        // Vectors back to back at the minimum issue interval on every chunk size.
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 8; v++) begin
                do_op(d, vt[v].a, vt[v].b, vt[v].cin, vt[v].sb, vt[v].s, vt[v].c, vt[v].o,
                      lats[d], 0, $sformatf("d%0d_v%0d", d, v));
            end
        end

        do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 4, 5, "backpressure");

        // Reset during the second BUSY cycle discards the partial result.
        iv[0]  = 1'b1;
        ia[0]  = 16'h0f0f;
        ib[0]  = 16'h0101;
        ic[0]  = 1'b0;
        isb[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_vld", 32'(ovd[0]), 32'd0);
        check("midrst_rdy", 32'(ird[0]), 32'd1);
        check("midrst_sum", 32'(sumd[0]), 32'd0);
        check("midrst_cout", 32'(cod[0]), 32'd0);
        check("midrst_ovf", 32'(ofd[0]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_emit", 32'(ovd[0]), 32'd0);
        end
        do_op(0, 16'd2, 16'd3, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0, 4, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
